// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts a command/write-data stream into SINGLE or INCR4 word transfers.
// Build option AHB_MST_BURST_EN enables INCR4, BUSY insertion and the 1KB-boundary reject.
module ahb_lite_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_burst,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HBURST,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic [2:0]        fsm_state
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_ERR} state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
`ifdef AHB_MST_BURST_EN
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_SEQ    = 2'b11;
`endif

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        beats;      // address phases still to complete
    logic              is_write;
    logic              hold;       // NONSEQ/SEQ presented last cycle and stalled
    logic              dphase;     // a data phase is in progress this cycle
    logic              err_acc;
    logic              accept, reject, burst_req, beat_req;
    logic              err_hit, err_first, addr_done, finish;

`ifdef AHB_MST_BURST_EN
    assign burst_req = cmd_burst;
    assign reject    = cmd_burst && (cmd_addr[9:2] > 8'hFC);
`else
    logic unused_burst;
    assign unused_burst = cmd_burst;
    assign burst_req    = 1'b0;
    assign reject       = 1'b0;
`endif
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cmd_addr[1:0];

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // cmd/wd senders hold valid and payload stable until ready is seen.
    assign cmd_ready = (state == S_IDLE) && !HRESET;
    assign accept    = cmd_valid && cmd_ready;
    assign err_hit   = dphase && HRESP;
    assign err_first = err_hit && !HREADY;
    assign beat_req  = !is_write || wd_valid || hold;
    assign wd_ready  = addr_done && is_write && wd_valid;

    assign HADDR     = addr;
    assign HWRITE    = is_write;
    assign HSIZE     = 3'b010;
    assign fsm_state = state;

    always_comb begin
        next_state = state;
        HTRANS     = TR_IDLE;
        addr_done  = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && !reject) next_state = S_ADDR;
            end
            S_ADDR: begin
                HTRANS = beat_req ? TR_NONSEQ : TR_IDLE;
                if (beat_req && HREADY) begin
                    addr_done  = 1'b1;
                    next_state = (beats == 3'd1) ? S_LAST : S_PIPE;
                end
            end
`ifdef AHB_MST_BURST_EN
            S_PIPE: begin
                // First ERROR cycle drops the pending address and cancels the rest of the burst.
                if (err_first) begin
                    next_state = S_ERR;
                end else begin
                    HTRANS = beat_req ? TR_SEQ : TR_BUSY;
                    if (beat_req && HREADY) begin
                        addr_done = 1'b1;
                        if (beats == 3'd1) next_state = S_LAST;
                    end
                end
            end
`endif
            S_LAST: begin
                if (err_first) begin
                    next_state = S_ERR;
                end else if (HREADY) begin
                    finish     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    finish     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= S_IDLE;
            addr     <= '0;
            beats    <= '0;
            is_write <= 1'b0;
            HBURST   <= 3'b000;
            HWDATA   <= '0;
            hold     <= 1'b0;
            dphase   <= 1'b0;
            err_acc  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= next_state;
            rd_valid <= dphase && HREADY && !HRESP && !is_write;
            if (dphase && HREADY && !HRESP && !is_write) rd_data <= HRDATA;
            done     <= finish || (accept && reject);
            err      <= (finish && (err_acc || err_hit)) || (accept && reject);
            hold     <= HTRANS[1] && !HREADY;
            if (accept && !reject) begin
                addr     <= {cmd_addr[ADDR_W-1:2], 2'b00};
                beats    <= burst_req ? 3'd4 : 3'd1;
                is_write <= cmd_write;
                HBURST   <= burst_req ? 3'b011 : 3'b000;
                err_acc  <= 1'b0;
            end else begin
                if (err_hit) err_acc <= 1'b1;
                if (addr_done) begin
                    addr  <= addr + ADDR_W'(4);
                    beats <= beats - 3'd1;
                    if (is_write) HWDATA <= wd_data;
                end
            end
            if (addr_done) dphase <= 1'b1;
            else if (HREADY || err_first) dphase <= 1'b0;
        end
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite bus initiator: turns a simple command/write-data stream into single or INCR4 word transfers on the shared bus. It consumes the HRDATA/HREADY/HRESP response returned through the slave response multiplexer and returns read data and error status to the local client. The block drives the address/control side that the bus decoder and slaves observe.

## Interface
- ADDR_W, 32, HADDR and cmd_addr width
- DATA_W, 32, HWDATA/HRDATA width; fixed word transfers, HSIZE=3'b010
- Clock and reset: one clock; reset is synchronous and active-high.
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE and not in reset
- cmd_write  in  1  1 = write, 0 = read
- cmd_burst  in  1  0 = SINGLE, 1 = INCR4
- cmd_addr  in  ADDR_W  start address; bits [1:0] ignored (forced 0)
- wd_valid / wd_ready / wd_data  in/out/in  1/1/DATA_W  write-data stream, one word per beat
- rd_valid  out  1  one-cycle pulse per completed read beat
- rd_data  out  DATA_W  read word, valid with rd_valid
- done  out  1  one-cycle pulse when a command finishes
- err  out  1  valid with done: 1 if any beat got ERROR or the command was rejected
- HADDR  out  ADDR_W; HTRANS  out  2; HWRITE  out  1; HBURST  out  3; HSIZE  out  3; HWDATA  out  DATA_W
- HRDATA  in  DATA_W; HREADY  in  1; HRESP  in  1  (0 = OKAY, 1 = ERROR)

## Operation
- States: IDLE, ADDR (first address phase), PIPE (data phase k overlapped with address phase k+1), LAST (final data phase), ERR (second ERROR cycle).
- Reset values: HTRANS=IDLE (2'b00), HADDR=0, HWRITE=0, HBURST=0, HWDATA=0, HSIZE=3'b010, rd_valid=0, rd_data=0, done=0, err=0, cmd_ready=0 while HRESET is high. State is IDLE.
- Acceptance: cmd_valid&cmd_ready latches the command. HBURST is 3'b000 for SINGLE and 3'b011 for INCR4. The beat counter is set to 1 or 4.
- 1KB rule: an INCR4 with cmd_addr[9:2] > 8'hFC is rejected. The block pulses done with err=1 on the next cycle and produces no bus activity.
- Beat addresses are start + 4k with no wrap.
- First beat: HTRANS=NONSEQ. For a write, HTRANS=IDLE while wd_valid=0, changing to NONSEQ when wd_valid=1.
- Burst write beats 2-4: HTRANS=SEQ if wd_valid=1, otherwise BUSY with the beat address held.
- BUSY may change to SEQ even while HREADY=0. NONSEQ and SEQ, once presented, are held until HREADY=1.
- An address phase completes on a cycle where HTRANS is NONSEQ or SEQ and HREADY=1.
  - On a write completion, wd_ready=1 in that cycle (wd_ready is combinational: HREADY & wd_valid & write beat presented) and wd_data is registered into HWDATA.
  - HWDATA is held through the data phase.
- A data phase completes on HREADY=1.
  - On a read completion, HRDATA is registered: rd_valid pulses the next cycle.
- After the last data phase: return to IDLE, done=1 for one cycle, err = accumulated error flag, HTRANS=IDLE.
- ERROR handling:
  - The first cycle has HRESP=1 and HREADY=0. In that same cycle HTRANS is driven IDLE combinationally and all remaining beats are cancelled.
  - Next state is ERR. It waits for HREADY=1, then done with err=1.
  - A read beat with ERROR produces no rd_valid.
- Reset mid-command: on the next edge, return to IDLE with reset values. No done pulse.

## Timing
- Single read, zero wait states: accept at T, NONSEQ at T+1, data phase T+2, rd_valid and done at T+3.
- INCR4 with zero wait states and no BUSY: NONSEQ at T+1, SEQ at T+2..T+4, data phases T+2..T+5, done at T+6.
- Each HREADY=0 cycle extends the current phase by one cycle. Each BUSY cycle adds one cycle.
- cmd_ready returns high the cycle done pulses.

## Configuration
- AHB_MST_BURST_EN defined: INCR4, BUSY insertion and the 1KB reject are implemented.
- AHB_MST_BURST_EN undefined:
  - cmd_burst is ignored and every command is a SINGLE (HBURST=0).
  - PIPE, BUSY and the reject logic are removed.
  - State sequence is IDLE→ADDR→LAST.

## Test plan
- Single read at 0x0000_1004, HRDATA=0xCAFE_F00D, zero waits: HADDR=0x1004 NONSEQ at T+1; rd_valid with 0xCAFE_F00D and done, err=0 at T+3.
- INCR4 write at 0x200, wd_valid stuck high with data 1..4: HTRANS NONSEQ,SEQ,SEQ,SEQ; HADDR 0x200..0x20C; HWDATA 1..4 in consecutive data phases; done at T+6.
- INCR4 write with wd_valid low for 2 cycles before beat 3: HTRANS shows BUSY at 0x208 for 2 cycles, then SEQ; wd_ready never asserts during BUSY; done at T+8.
- INCR4 read where beat 2 gets ERROR (HRESP=1/HREADY=0, then HRESP=1/HREADY=1): HTRANS=IDLE in the first ERROR cycle; exactly one rd_valid; done with err=1; no further address phases.
- INCR4 at 0x3F8: done with err=1 one cycle after accept; HTRANS stays IDLE.
- HREADY=0 for 3 cycles during the first data phase of a single write, then HRESET pulsed mid-burst on a later command: HWDATA held for the 3 wait cycles; after reset, all outputs are at their reset values and there is no done pulse.
